// File: rtl/de_ser_pkg.sv
// Shared types, default widths and index helpers for the stream de-serializer.
package de_ser_pkg;

  // Default configuration and the widths derived from it.
  localparam int WORD_W    = 8;
  localparam int MAX_WORDS = 4;
  localparam int REG_W     = WORD_W * MAX_WORDS;
  localparam int NB_W      = $clog2(REG_W + 1);
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Number of stream words needed for num_bits, capped at the buffer depth.
  function automatic int words_for_bits(input int num_bits, input int word_w,
                                        input int max_words);
    int n;
    n = (num_bits + word_w - 1) / word_w;
    if (n > max_words) n = max_words;
    return n;
  endfunction

  // Buffer word addressed by beat cnt; out-of-range beats map to word 0 so the
  // caller's part-select always stays inside the buffer.
  function automatic int word_index(input int cnt, input int n, input logic msb_first);
    if (cnt >= n) return 0;
    return msb_first ? (n - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/ds_beat_counter.sv
// Beat counter for one stream side: counts handshakes up to the latched word count.
module ds_beat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] n_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             active_o,
  output logic             fin_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on a new command, otherwise step on each handshake.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign active_o = (cnt_q < n_i);
  // This side will have moved all its words once the current edge has passed.
  assign fin_o    = (cnt_d == n_i);

endmodule

// File: rtl/stream_de_serializer.sv
// Word-wise serializer/deserializer: streams a latched parallel word out on a
// valid/ready TX channel while assembling an equal-length word from RX.
module stream_de_serializer
  import de_ser_pkg::state_e, de_ser_pkg::IDLE, de_ser_pkg::RUN, de_ser_pkg::DONE,
         de_ser_pkg::words_for_bits, de_ser_pkg::word_index;
#(
  parameter  int MAX_WORDS = 4,
  parameter  int WORD_W    = 8,
  localparam int REG_W     = WORD_W * MAX_WORDS,
  localparam int NB_W      = $clog2(REG_W + 1),
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              START_I,
  input  logic              ABORT_I,
  input  logic              MSB_FIRST_I,
  input  logic [NB_W-1:0]   NUM_BITS_I,
  input  logic [REG_W-1:0]  REG_I,
  output logic [REG_W-1:0]  REG_O,
  output logic [WORD_W-1:0] TX_DATA_O,
  output logic              TX_VALID_O,
  input  logic              TX_READY_I,
  input  logic [WORD_W-1:0] RX_DATA_I,
  input  logic              RX_VALID_I,
  output logic              RX_READY_O,
  output logic              BUSY_O,
  output logic              DONE_O
);

  state_e           state_q;
  logic [REG_W-1:0] tx_buf_q, rx_buf_q, reg_q;
  logic [CNT_W-1:0] n_q;
  logic [NB_W-1:0]  num_bits_q;
  logic             msb_first_q;

  logic [CNT_W-1:0] n_start;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             tx_active, rx_active, tx_fin, rx_fin;
  logic             run, start, tx_fire, rx_fire;
  int               tx_idx, rx_idx;
  logic [REG_W-1:0] rx_buf_d, mask;

  assign n_start = CNT_W'(words_for_bits(int'(NUM_BITS_I), WORD_W, MAX_WORDS));
  assign run     = (state_q == RUN);
  assign start   = (state_q == IDLE) && START_I;
  assign tx_fire = run && tx_active && TX_READY_I;
  assign rx_fire = run && rx_active && RX_VALID_I;

  ds_beat_counter #(.CNT_W(CNT_W)) u_tx_cnt (
    .clk_i(CLK_I), .rst_i(RST_I), .clr_i(start), .inc_i(tx_fire), .n_i(n_q),
    .cnt_o(tx_cnt), .active_o(tx_active), .fin_o(tx_fin)
  );

  ds_beat_counter #(.CNT_W(CNT_W)) u_rx_cnt (
    .clk_i(CLK_I), .rst_i(RST_I), .clr_i(start), .inc_i(rx_fire), .n_i(n_q),
    .cnt_o(rx_cnt), .active_o(rx_active), .fin_o(rx_fin)
  );

  // Word addressing, RX buffer with the current beat merged in, and result mask.
  always_comb begin
    tx_idx   = word_index(int'(tx_cnt), int'(n_q), msb_first_q);
    rx_idx   = word_index(int'(rx_cnt), int'(n_q), msb_first_q);
    rx_buf_d = rx_buf_q;
    if (rx_fire) rx_buf_d[rx_idx*WORD_W +: WORD_W] = RX_DATA_I;
    mask = '0;
    for (int i = 0; i < REG_W; i++) mask[i] = (i < int'(num_bits_q));
  end

  // Control FSM with the TX/RX buffers and the result register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      // NOTE: the buffers are small and must read back as zero after reset, so they are reset too.
      state_q     <= IDLE;
      tx_buf_q    <= '0;
      rx_buf_q    <= '0;
      reg_q       <= '0;
      n_q         <= '0;
      num_bits_q  <= '0;
      msb_first_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START_I) begin
            tx_buf_q    <= REG_I;
            rx_buf_q    <= '0;
            n_q         <= n_start;
            num_bits_q  <= NUM_BITS_I;
            msb_first_q <= MSB_FIRST_I;
            if (n_start == '0) begin
              reg_q   <= '0;
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (ABORT_I) begin
            state_q <= IDLE;
          end else begin
            rx_buf_q <= rx_buf_d;
            if (tx_fin && rx_fin) begin
              reg_q   <= rx_buf_d & mask;
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REG_O      = reg_q;
  assign BUSY_O     = run;
  assign DONE_O     = (state_q == DONE);
  assign TX_VALID_O = run && tx_active;
  assign RX_READY_O = run && rx_active;
  assign TX_DATA_O  = TX_VALID_O ? tx_buf_q[tx_idx*WORD_W +: WORD_W] : '0;

endmodule

// File: tb/tb_stream_de_serializer.sv
// Self-checking bench for stream_de_serializer (WORD_W=8, MAX_WORDS=4).
module tb_stream_de_serializer;
  import de_ser_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort_i, msb_first;
  logic [NB_W-1:0]   num_bits;
  logic [REG_W-1:0]  reg_i, reg_o;
  logic [WORD_W-1:0] tx_data, rx_data;
  logic              tx_valid, tx_ready, rx_valid, rx_ready, busy, done;

  int total = 0;
  int bad   = 0;
  bit abort_at_start = 1'b0;

  typedef struct {
    logic [31:0] reg_i;
    int          nb;
    bit          msb;
    int          n;
    logic [31:0] rx_words;  // k-th RX beat in bits [8k+7:8k]
    logic [31:0] tx_words;  // k-th expected TX beat in bits [8k+7:8k]
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[5];

  stream_de_serializer #(.MAX_WORDS(4), .WORD_W(8)) dut (
    .CLK_I(clk), .RST_I(rst), .START_I(start), .ABORT_I(abort_i),
    .MSB_FIRST_I(msb_first), .NUM_BITS_I(num_bits), .REG_I(reg_i), .REG_O(reg_o),
    .TX_DATA_O(tx_data), .TX_VALID_O(tx_valid), .TX_READY_I(tx_ready),
    .RX_DATA_I(rx_data), .RX_VALID_I(rx_valid), .RX_READY_O(rx_ready),
    .BUSY_O(busy), .DONE_O(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: word count, TX word order and the assembled/masked result.
  function automatic int model_n(input int nb);
    int n;
    n = (nb + WORD_W - 1) / WORD_W;
    return (n > MAX_WORDS) ? MAX_WORDS : n;
  endfunction

  function automatic logic [7:0] model_tx(input logic [31:0] r, input int n, input bit msb,
                                          input int k);
    int pos;
    pos = msb ? (n - 1 - k) : k;
    return 8'(r >> (8 * pos));
  endfunction

  function automatic logic [31:0] model_reg(input logic [7:0] rxw[4], input int n, input int nb,
                                            input bit msb);
    logic [63:0] acc;
    acc = '0;
    for (int k = 0; k < n; k++) acc = acc | (64'(rxw[k]) << (8 * (msb ? (n - 1 - k) : k)));
    if (nb < 32) acc = acc & ((64'd1 << nb) - 64'd1);
    return acc[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] r, input int nb, input bit msb);
    reg_i     = r;
    num_bits  = NB_W'(nb);
    msb_first = msb;
    start     = 1'b1;
    abort_i   = abort_at_start;
    tick();
    start     = 1'b0;
    abort_i   = 1'b0;
    reg_i     = $urandom;
    num_bits  = NB_W'($urandom_range(0, 40));
    msb_first = ~msb;
    check("start_busy", busy, model_n(nb) > 0);
    check("start_done", done, model_n(nb) == 0);
  endtask

  // Randomised transfer against the reference rules.
  task automatic run_rand(input logic [31:0] r, input int nb, input bit msb, input bit stray,
                          input bit skew);
    int          n, tk, rk, tx_end;
    bit          done_seen, prev_stall, tx_fire, rx_fire, rx_allowed;
    logic [7:0]  rxw[4];
    logic [7:0]  prev_data;
    logic [31:0] exp_reg;
    n = model_n(nb);
    for (int k = 0; k < 4; k++) rxw[k] = 8'($urandom);
    exp_reg = model_reg(rxw, n, nb, msb);
    do_start(r, nb, msb);
    tk = 0; rk = 0; tx_end = -1; done_seen = 0; prev_stall = 0; prev_data = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (tk == n && rk == n) begin
        check("done_pulse", done, 1'b1);
        check("done_reg", reg_o, exp_reg);
        done_seen = 1;
        break;
      end
      check("no_early_done", done, 1'b0);
      check("tx_valid_rule", tx_valid, tk < n);
      check("rx_ready_rule", rx_ready, rk < n);
      if (prev_stall) check("tx_data_stable", tx_data, prev_data);
      start = (stray && cyc == 1);
      if (start) reg_i = $urandom;
      tx_ready   = 1'($urandom_range(0, 1));
      rx_allowed = !skew || (tx_end >= 0 && cyc >= tx_end + 5);
      rx_valid   = rx_allowed && 1'($urandom_range(0, 1));
      rx_data    = (rk < n) ? rxw[rk] : 8'($urandom);
      tx_fire    = tx_valid && tx_ready;
      rx_fire    = rx_ready && rx_valid;
      if (tx_fire) check("tx_data", tx_data, model_tx(r, n, msb, tk));
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      tick();
      start = 1'b0;
      if (tx_fire) begin
        tk++;
        if (tk == n) tx_end = cyc;
      end
      if (rx_fire) rk++;
    end
    check("xfer_finished", done_seen, 1'b1);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    tick();
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'hDEADBEEF, 32, 1'b0, 4, 32'h44332211, 32'hDEADBEEF, 32'h44332211};
    vecs[1] = '{32'h00000ABC, 12, 1'b1, 2, 32'h0000F5FF, 32'h0000BC0A, 32'h00000FF5};
    vecs[2] = '{32'h12345678, 40, 1'b0, 4, 32'hD4C3B2A1, 32'h12345678, 32'hD4C3B2A1};
    vecs[3] = '{32'hFFFFFFFF, 0,  1'b0, 0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4] = '{32'hCAFE1234, 20, 1'b1, 3, 32'h00DEBC9A, 32'h003412FE, 32'h000ABCDE};

    rst = 1'b1; start = 1'b0; abort_i = 1'b0; msb_first = 1'b0; num_bits = '0;
    reg_i = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #1;
    check("rst_reg", reg_o, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_data", tx_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();

    // Directed table: both partners always ready, beats at E1..En.
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].reg_i, vecs[v].nb, vecs[v].msb);
      for (int k = 0; k < vecs[v].n; k++) begin
        check("tbl_tx_valid", tx_valid, 1'b1);
        check("tbl_tx_data", tx_data, vecs[v].tx_words[8*k +: 8]);
        check("tbl_rx_ready", rx_ready, 1'b1);
        check("tbl_no_done", done, 1'b0);
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        rx_data  = vecs[v].rx_words[8*k +: 8];
        tick();
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      check("tbl_done", done, 1'b1);
      check("tbl_reg", reg_o, vecs[v].exp_reg);
      check("tbl_tx_quiet", tx_valid, 1'b0);
      check("tbl_rx_quiet", rx_ready, 1'b0);
      tick();
      check("tbl_done_once", done, 1'b0);
      check("tbl_idle", busy, 1'b0);
    end

    // Abort after 2 of 4 beats: back to IDLE, no done, result kept.
    do_start(32'hAABBCCDD, 32, 1'b0);
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    tick();
    tick();
    tx_ready = 1'b0; rx_valid = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_tx_valid", tx_valid, 1'b0);
    check("abort_rx_ready", rx_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", done, 1'b0);
      check("abort_reg_kept", reg_o, vecs[4].exp_reg);
      tick();
    end

    // Reset asserted between edges during RUN.
    do_start(32'h55AA55AA, 32, 1'b1);
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h3C;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_reg", reg_o, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    run_rand(32'h0BADF00D, 32, 1'b0, 1'b0, 1'b0);

    // Stray start during RUN, RX skewed behind TX, and start with abort in IDLE.
    run_rand(32'h01020304, 32, 1'b0, 1'b1, 1'b0);
    run_rand(32'hFEEDC0DE, 32, 1'b1, 1'b0, 1'b1);
    abort_at_start = 1'b1;
    run_rand(32'h13579BDF, 24, 1'b0, 1'b0, 1'b0);
    abort_at_start = 1'b0;

    // Random transfers.
    for (int i = 0; i < 12; i++)
      run_rand($urandom, $urandom_range(0, 40), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
